// File: rtl/rotary_pkg.sv
// Shared encodings for the rotary encoder front end: quadrature FSM states,
// Gray-code phase pairs and the FSM transition function.
package rotary_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_R1   = 3'd1,
    ST_R2   = 3'd2,
    ST_R3   = 3'd3,
    ST_L1   = 3'd4,
    ST_L2   = 3'd5,
    ST_L3   = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Clockwise Gray order is 00->01->11->10->00. Any two-bit jump lands in ERR.
  function automatic state_t next_state(input state_t s, input logic [1:0] ph);
    state_t n;
    n = s;
    case (s)
      ST_IDLE: begin
        case (ph)
          PH_01:   n = ST_R1;
          PH_10:   n = ST_L1;
          PH_11:   n = ST_ERR;
          default: n = ST_IDLE;
        endcase
      end
      ST_R1: begin
        case (ph)
          PH_11:   n = ST_R2;
          PH_00:   n = ST_IDLE;
          PH_10:   n = ST_ERR;
          default: n = ST_R1;
        endcase
      end
      ST_R2: begin
        case (ph)
          PH_10:   n = ST_R3;
          PH_01:   n = ST_R1;
          PH_00:   n = ST_ERR;
          default: n = ST_R2;
        endcase
      end
      ST_R3: begin
        case (ph)
          PH_00:   n = ST_IDLE;
          PH_11:   n = ST_R2;
          PH_01:   n = ST_ERR;
          default: n = ST_R3;
        endcase
      end
      ST_L1: begin
        case (ph)
          PH_11:   n = ST_L2;
          PH_00:   n = ST_IDLE;
          PH_01:   n = ST_ERR;
          default: n = ST_L1;
        endcase
      end
      ST_L2: begin
        case (ph)
          PH_01:   n = ST_L3;
          PH_10:   n = ST_L1;
          PH_00:   n = ST_ERR;
          default: n = ST_L2;
        endcase
      end
      ST_L3: begin
        case (ph)
          PH_00:   n = ST_IDLE;
          PH_11:   n = ST_L2;
          PH_10:   n = ST_ERR;
          default: n = ST_L3;
        endcase
      end
      default: begin
        n = (ph == PH_00) ? ST_IDLE : ST_ERR;
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rotary_debounce.sv
// Single encoder phase: two-flop synchroniser followed by a debounce counter.
// With ROTARY_FILTER_GLITCH_COUNT_EN, glitch_o flags each rejected bounce.
module rotary_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
  output logic glitch_o,
`endif
  output logic clean_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 clean_q;
  logic                 clean_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 reject;

  // The clean value only follows after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    reject  = 1'b0;
    if (sync2_q == clean_q) begin
      cnt_d  = '0;
      reject = (cnt_q != '0);
    end else if (cnt_q == CNT_LAST) begin
      clean_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
  assign glitch_o = reject;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: rtl/rotary_filter.sv
// Rotary encoder front end: debounce both phases, decode detents into step
// pulses and track position. Optional ROTARY_FILTER_GLITCH_COUNT_EN adds glitch_count.
module rotary_filter
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rotary,
  output logic [1:0] rotary_clean,
  output logic       step_right,
  output logic       step_left,
  output logic [7:0] position,
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
  output logic [7:0] glitch_count,
`endif
  output logic [2:0] fsm_state
);

  logic [1:0] clean;
  state_t     state_q;
  state_t     state_n;
  logic       step_right_q;
  logic       step_left_q;
  logic [7:0] position_q;
  logic       cw_done;
  logic       ccw_done;

`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
  logic [1:0] glitch_ph;
  logic       glitch_evt;
  logic [7:0] glitch_q;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_phase
    rotary_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (rotary[g]),
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
      .glitch_o(glitch_ph[g]),
`endif
      .clean_o (clean[g])
    );
  end

  assign state_n  = next_state(state_q, clean);
  assign cw_done  = (state_q == ST_R3) && (clean == PH_00);
  assign ccw_done = (state_q == ST_L3) && (clean == PH_00);

  // Step pulses and position move together on the edge that closes a detent.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      step_right_q <= 1'b0;
      step_left_q  <= 1'b0;
      position_q   <= 8'h00;
    end else begin
      state_q      <= state_n;
      step_right_q <= cw_done;
      step_left_q  <= ccw_done;
      if (cw_done) begin
        position_q <= position_q + 8'd1;
      end else if (ccw_done) begin
        position_q <= position_q - 8'd1;
      end
    end
  end

`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
  // A bounce on either phase and an ERR entry in the same cycle count once.
  assign glitch_evt = (|glitch_ph) || ((state_n == ST_ERR) && (state_q != ST_ERR));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      glitch_q <= 8'h00;
    end else if (glitch_evt && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_count = glitch_q;
`endif

  assign rotary_clean = clean;
  assign step_right   = step_right_q;
  assign step_left    = step_left_q;
  assign position     = position_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_rotary_filter.sv
// Directed bench for rotary_filter with DEBOUNCE_CYCLES=4 (clean follows 6 cycles after a pin edge).
module tb_rotary_filter;
  import rotary_pkg::*;

  logic       clock;
  logic       reset;
  logic [1:0] rotary;
  logic [1:0] rotary_clean;
  logic       step_right;
  logic       step_left;
  logic [7:0] position;
  logic [2:0] fsm_state;
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
  logic [7:0] glitch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rotary_filter #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rotary      (rotary),
    .rotary_clean(rotary_clean),
    .step_right  (step_right),
    .step_left   (step_left),
    .position    (position),
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
    .glitch_count(glitch_count),
`endif
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // pulse monitor, sampled on the falling edge
  int  r_pulses = 0;
  int  l_pulses = 0;
  int  wide     = 0;
  int  both     = 0;
  int  clean_chg = 0;
  logic       prev_r = 1'b0;
  logic       prev_l = 1'b0;
  logic [1:0] prev_clean = 2'b00;

  always @(negedge clock) begin
    if (step_right) r_pulses++;
    if (step_left) l_pulses++;
    if ((step_right && prev_r) || (step_left && prev_l)) wide++;
    if (step_right && step_left) both++;
    if (rotary_clean != prev_clean) clean_chg++;
    prev_r     = step_right;
    prev_l     = step_left;
    prev_clean = rotary_clean;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic hold(input logic [1:0] ph, input int n);
    rotary = ph;
    repeat (n) @(negedge clock);
  endtask

  task automatic detent_cw();
    hold(PH_01, 10);
    hold(PH_11, 10);
    hold(PH_10, 10);
    hold(PH_00, 10);
  endtask

  task automatic detent_ccw();
    hold(PH_10, 10);
    hold(PH_11, 10);
    hold(PH_01, 10);
    hold(PH_00, 10);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int r0, l0, bad, lat;
    rotary = 2'b00;
    reset  = 1'b0;

    // 1: reset state and idle
    repeat (3) @(negedge clock);
    check("rst_clean", 32'(rotary_clean), 32'h0);
    check("rst_pos", 32'(position), 32'h00);
    check("rst_steps", 32'({step_right, step_left}), 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (step_right || step_left || position != 8'h00 || rotary_clean != 2'b00) bad++;
    end
    check("idle_20", 32'(bad), 32'h0);

    // 2: one clockwise detent
    r0 = r_pulses; l0 = l_pulses;
    detent_cw();
    check("cw_rpulse", 32'(r_pulses - r0), 32'd1);
    check("cw_lpulse", 32'(l_pulses - l0), 32'd0);
    check("cw_pos", 32'(position), 32'h01);

    // 3: counter-clockwise from 00 wraps to FF, then 256 clockwise detents
    do_reset();
    r0 = r_pulses; l0 = l_pulses;
    detent_ccw();
    check("ccw_lpulse", 32'(l_pulses - l0), 32'd1);
    check("ccw_rpulse", 32'(r_pulses - r0), 32'd0);
    check("ccw_pos", 32'(position), 32'hFF);
    r0 = r_pulses;
    for (int i = 0; i < 256; i++) detent_cw();
    check("cw256_pulses", 32'(r_pulses - r0), 32'd256);
    check("cw256_pos", 32'(position), 32'hFF);

    // 4: five 2-cycle bounces on A, then stable 01
    do_reset();
    hold(PH_00, 4);
    clean_chg = 0;
    for (int i = 0; i < 5; i++) begin
      hold(PH_01, 2);
      hold(PH_00, 2);
    end
    rotary = PH_01;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (lat < 0 && rotary_clean == PH_01) lat = i;
    end
    check("bounce_latency", 32'(lat), 32'd6);
    check("bounce_changes", 32'(clean_chg), 32'd1);
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
    check("glitch_bounce", 32'(glitch_count), 32'd5);
`endif

    // 5: partial turn reversed, then a double-phase jump into ERR
    r0 = r_pulses; l0 = l_pulses;
    hold(PH_11, 10);
    hold(PH_01, 10);
    hold(PH_00, 10);
    check("partial_pulses", 32'((r_pulses - r0) + (l_pulses - l0)), 32'd0);
    check("partial_pos", 32'(position), 32'h00);
    hold(PH_11, 10);
    check("err_state", 32'(fsm_state), 32'(ST_ERR));
`ifdef ROTARY_FILTER_GLITCH_COUNT_EN
    check("glitch_err", 32'(glitch_count), 32'd6);
`endif
    hold(PH_10, 10);
    check("err_stays", 32'(fsm_state), 32'(ST_ERR));
    hold(PH_00, 10);
    check("err_exit", 32'(fsm_state), 32'(ST_IDLE));
    check("err_nopulse", 32'((r_pulses - r0) + (l_pulses - l0)), 32'd0);
    detent_cw();
    check("post_err_pulse", 32'(r_pulses - r0), 32'd1);
    check("post_err_pos", 32'(position), 32'h01);

    // 6: asynchronous reset while in R3
    hold(PH_01, 10);
    hold(PH_11, 10);
    hold(PH_10, 10);
    check("in_r3", 32'(fsm_state), 32'(ST_R3));
    #2 reset = 1'b0;
    #1;
    check("async_pos", 32'(position), 32'h00);
    check("async_state", 32'(fsm_state), 32'(ST_IDLE));
    check("async_clean", 32'(rotary_clean), 32'h0);
    rotary = PH_00;
    repeat (2) @(negedge clock);
    r0 = r_pulses;
    reset = 1'b1;
    hold(PH_00, 20);
    check("post_rst_nopulse", 32'(r_pulses - r0), 32'd0);
    check("post_rst_pos", 32'(position), 32'h00);

    check("pulse_width", 32'(wide), 32'd0);
    check("never_both", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
